// File: rtl/i2c_rx_checker.sv
// Self-checking receiver for the I2C slave model: compares received bytes against an
// expected-byte FIFO, tracks START..STOP frames and keeps saturating statistics.
module i2c_rx_checker #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    input  logic                 clear_i,
    input  logic                 exp_wr_i,
    input  logic [DATA_SIZE-1:0] exp_data_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [DATA_SIZE-1:0] rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 mismatch_o,
    output logic [CNT_W-1:0]     match_cnt_o,
    output logic [CNT_W-1:0]     mismatch_cnt_o,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     byte_cnt_o,
    output logic [DATA_SIZE-1:0] last_exp_o,
    output logic [DATA_SIZE-1:0] last_got_o,
    output logic                 fifo_empty_o,
    output logic                 fifo_full_o,
    output logic [3:0]           err_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t               state, state_n;
    logic                 rst;
    logic [2:0]           start_sync, stop_sync, valid_sync;
    logic                 evt_start, evt_stop, evt_byte;
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [DATA_SIZE-1:0] head;
    logic                 do_push, hit;
    logic [CNT_W-1:0]     byte_cnt_n;
    logic [1:0]           frame_inc;
    logic                 proto;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign rst       = preset_i | clear_i;
    assign evt_start = start_sync[1] & ~start_sync[2];
    assign evt_stop  = stop_sync[1]  & ~stop_sync[2];
    assign evt_byte  = valid_sync[1] & ~valid_sync[2];

    assign fifo_empty_o = (wr_ptr == rd_ptr);
    assign fifo_full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head         = mem[rd_ptr[AW-1:0]];
    assign do_push      = exp_wr_i && !fifo_full_o;
    assign hit          = !fifo_empty_o && (head == rx_data_i);

    // Events of one cycle are applied in order byte -> start -> stop, so each later
    // event sees the state left by the earlier one.
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt_o;
        frame_inc  = 2'd0;
        proto      = 1'b0;
        if (evt_byte) begin
            if (state_n == IDLE) proto = 1'b1;
            else                 byte_cnt_n = sat_inc(byte_cnt_o, 2'd1);
        end
        if (evt_start) begin
            if (state_n == FRAME) frame_inc = frame_inc + 2'd1;
            state_n    = FRAME;
            byte_cnt_n = '0;
        end
        if (evt_stop) begin
            if (state_n == FRAME) begin
                frame_inc = frame_inc + 2'd1;
                state_n   = IDLE;
            end else begin
                proto = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= exp_data_i;
    end

    always_ff @(posedge pclk_i) begin
        if (rst) begin
            state          <= IDLE;
            start_sync     <= '0;
            stop_sync      <= '0;
            valid_sync     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            mismatch_o     <= 1'b0;
            match_cnt_o    <= '0;
            mismatch_cnt_o <= '0;
            frame_cnt_o    <= '0;
            byte_cnt_o     <= '0;
            last_exp_o     <= '0;
            last_got_o     <= '0;
            err_o          <= '0;
        end else begin
            start_sync  <= {start_sync[1:0], start_i};
            stop_sync   <= {stop_sync[1:0], stop_i};
            valid_sync  <= {valid_sync[1:0], rx_valid_i};
            state       <= state_n;
            byte_cnt_o  <= byte_cnt_n;
            frame_cnt_o <= sat_inc(frame_cnt_o, frame_inc);
            mismatch_o  <= evt_byte && !hit;
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (exp_wr_i && fifo_full_o) err_o[3] <= 1'b1;
            if (proto) err_o[1] <= 1'b1;
            if (evt_byte) begin
                last_got_o <= rx_data_i;
                if (fifo_empty_o) begin
                    err_o[2]       <= 1'b1;
                    last_exp_o     <= '0;
                    mismatch_cnt_o <= sat_inc(mismatch_cnt_o, 2'd1);
                end else begin
                    rd_ptr     <= rd_ptr + (AW+1)'(1);
                    last_exp_o <= head;
                    if (hit) begin
                        match_cnt_o <= sat_inc(match_cnt_o, 2'd1);
                    end else begin
                        err_o[0]       <= 1'b1;
                        mismatch_cnt_o <= sat_inc(mismatch_cnt_o, 2'd1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_rx_checker.sv
// Directed/randomized bench for i2c_rx_checker against a queue-based reference model.
module tb_i2c_rx_checker;
    logic        pclk_i = 1'b0;
    logic        preset_i = 1'b1, clear_i = 1'b0, exp_wr_i = 1'b0;
    logic [7:0]  exp_data_i = '0, rx_data_i = '0;
    logic        start_i = 1'b0, stop_i = 1'b0, rx_valid_i = 1'b0;
    logic        mismatch_o, fifo_empty_o, fifo_full_o;
    logic [15:0] match_cnt_o, mismatch_cnt_o, frame_cnt_o, byte_cnt_o;
    logic [7:0]  last_exp_o, last_got_o;
    logic [3:0]  err_o;

    i2c_rx_checker #(.DATA_SIZE(8), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .pclk_i(pclk_i), .preset_i(preset_i), .clear_i(clear_i),
        .exp_wr_i(exp_wr_i), .exp_data_i(exp_data_i),
        .start_i(start_i), .stop_i(stop_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .mismatch_o(mismatch_o), .match_cnt_o(match_cnt_o),
        .mismatch_cnt_o(mismatch_cnt_o), .frame_cnt_o(frame_cnt_o),
        .byte_cnt_o(byte_cnt_o), .last_exp_o(last_exp_o), .last_got_o(last_got_o),
        .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .err_o(err_o)
    );

    always #5 pclk_i = ~pclk_i;

    int checks = 0, failures = 0, pulses_seen = 0;

    // reference model
    logic [7:0] exp_q[$];
    int         m_match, m_mism, m_frames, m_bytes, m_pulses = 0;
    logic [7:0] m_last_exp, m_last_got;
    logic [3:0] m_err;
    bit         m_in_frame;

    always @(negedge pclk_i) if (mismatch_o === 1'b1) pulses_seen++;

    function automatic void model_reset();
        exp_q.delete();
        m_match = 0; m_mism = 0; m_frames = 0; m_bytes = 0;
        m_last_exp = '0; m_last_got = '0; m_err = '0; m_in_frame = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge pclk_i);
    endtask

    task automatic do_reset(input bit use_clear);
        if (use_clear) clear_i = 1'b1; else preset_i = 1'b1;
        tick(2);
        clear_i = 1'b0; preset_i = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic push(input logic [7:0] b);
        exp_data_i = b; exp_wr_i = 1'b1;
        tick(1);
        exp_wr_i = 1'b0;
        if (exp_q.size() == 16) m_err[3] = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic send_start();
        start_i = 1'b1; tick(3); start_i = 1'b0; tick(3);
        if (m_in_frame) m_frames++;
        m_in_frame = 1; m_bytes = 0;
    endtask

    task automatic send_stop();
        stop_i = 1'b1; tick(3); stop_i = 1'b0; tick(3);
        if (m_in_frame) begin m_frames++; m_in_frame = 0; end
        else m_err[1] = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b; rx_valid_i = 1'b1; tick(4); rx_valid_i = 1'b0; tick(3);
        if (!m_in_frame) m_err[1] = 1'b1;
        else m_bytes++;
        m_last_got = b;
        if (exp_q.size() == 0) begin
            m_err[2] = 1'b1; m_mism++; m_pulses++; m_last_exp = '0;
        end else begin
            m_last_exp = exp_q.pop_front();
            if (m_last_exp == b) m_match++;
            else begin m_mism++; m_pulses++; m_err[0] = 1'b1; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".match_cnt"},    32'(match_cnt_o),    32'(m_match));
        chk({t, ".mismatch_cnt"}, 32'(mismatch_cnt_o), 32'(m_mism));
        chk({t, ".frame_cnt"},    32'(frame_cnt_o),    32'(m_frames));
        chk({t, ".byte_cnt"},     32'(byte_cnt_o),     32'(m_bytes));
        chk({t, ".last_exp"},     32'(last_exp_o),     32'(m_last_exp));
        chk({t, ".last_got"},     32'(last_got_o),     32'(m_last_got));
        chk({t, ".fifo_empty"},   32'(fifo_empty_o),   32'(exp_q.size() == 0));
        chk({t, ".fifo_full"},    32'(fifo_full_o),    32'(exp_q.size() == 16));
        chk({t, ".err"},          32'(err_o),          32'(m_err));
        chk({t, ".pulses"},       32'(pulses_seen),    32'(m_pulses));
    endtask

    initial begin
        logic [7:0] a, b, v;
        logic [7:0] vals[16];
        int n;

        // reset state
        tick(2);
        preset_i = 1'b0;
        model_reset();
        tick(1);
        check_all("reset");
        chk("reset.mismatch_o", 32'(mismatch_o), 32'd0);

        // 1: two matching bytes in one frame
        a = 8'hA5; b = 8'h3C;
        push(a); push(b);
        send_start(); send_byte(a); send_byte(b); send_stop();
        check_all("t1");
        chk("t1.err_zero", 32'(err_o), 32'd0);

        // 2: single mismatching byte (random expected, one bit flipped)
        do_reset(1'b1);
        a = 8'($urandom_range(0, 255));
        b = a ^ (8'd1 << $urandom_range(0, 7));
        push(a); send_start();
        rx_data_i = b; rx_valid_i = 1'b1;
        tick(3);
        chk("t2.pulse_high", 32'(mismatch_o), 32'd1);
        tick(1);
        chk("t2.pulse_gone", 32'(mismatch_o), 32'd0);
        rx_valid_i = 1'b0; tick(3);
        m_bytes++; m_last_got = b; m_last_exp = exp_q.pop_front();
        m_mism++; m_pulses++; m_err[0] = 1'b1;
        check_all("t2");
        chk("t2.err_mism", 32'(err_o), 32'b0001);

        // 3: byte with empty expected FIFO
        do_reset(1'b0);
        send_start(); send_byte(8'h11);
        check_all("t3");
        chk("t3.unf", 32'(err_o[2]), 32'd1);

        // 4: overfill FIFO, then drain with 16 matching bytes
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'($urandom_range(0, 255));
            push(vals[i]);
        end
        push(8'($urandom_range(0, 255)));
        tick(1);
        check_all("t4.full");
        chk("t4.ovf", 32'(err_o[3]), 32'd1);
        send_start();
        for (int i = 0; i < 16; i++) send_byte(vals[i]);
        send_stop();
        check_all("t4.drain");
        chk("t4.match16", 32'(match_cnt_o), 32'd16);

        // 5: repeated START, then STOP while idle
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
        send_start(); send_byte(exp_q[0]);
        send_start(); send_byte(exp_q[0]); send_byte(exp_q[0]); send_stop();
        check_all("t5.frames");
        chk("t5.byte_cnt", 32'(byte_cnt_o), 32'd2);
        send_stop();
        check_all("t5.idle_stop");

        // randomized frames with mixed match/mismatch
        do_reset(1'b1);
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 4);
            send_start();
            for (int k = 0; k < n; k++) begin
                v = 8'($urandom_range(0, 255));
                push(v);
                if ($urandom_range(0, 1) == 1) send_byte(v);
                else send_byte(v ^ 8'($urandom_range(1, 255)));
            end
            send_stop();
            check_all("rand");
        end

        // 6: reset mid-frame, then STOP -> protocol error only
        do_reset(1'b0);
        push(8'h42);
        send_start(); send_byte(8'h42);
        do_reset(1'b0);
        send_stop();
        check_all("t6");
        chk("t6.err_proto", 32'(err_o), 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
